// File: rtl/decode_prefetch_pkg.sv
// Shared constants and helpers for the decode prefetch queue.
// Imported by dpq_fifo and decode_prefetch_queue.
package decode_prefetch_pkg;

  localparam int INST_W       = 32;
  localparam int HALF_W       = 16;
  localparam int ARM_PC_INC   = 4;
  localparam int THUMB_PC_INC = 2;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] HALF_ALIGN_MASK = 32'hFFFF_FFFE;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dpq_fifo.sv
// Word storage for the prefetch queue: pointers, count, array.
// Pointers wrap naturally because DEPTH is a power of two.
module dpq_fifo
  import decode_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      push,
  input  logic [INST_W-1:0]         wdata,
  input  logic                      pop,
  output logic [INST_W-1:0]         rdata,
  output logic [level_w(DEPTH)-1:0] count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [INST_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;

  // Pointer and occupancy tracking; flush and reset empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on accepted words.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/decode_prefetch_queue.sv
// Instruction prefetch queue between fetch and ARM/Thumb decode.
// Optional fetch-to-decode bypass: DECODE_PREFETCH_BYPASS_EN.
module decode_prefetch_queue
  import decode_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     thumb,
  input  logic                     flush,
  input  logic [31:0]              flush_pc,
  output logic [31:0]              fetch_addr,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_data,
  output logic                     fetch_ready,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_code,
  output logic [31:0]              dec_pc,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = level_w(DEPTH);

  logic [LW-1:0]     count;
  logic              full;
  logic              empty;
  logic [INST_W-1:0] rdata;
  logic [INST_W-1:0] word;
  logic [INST_W-1:0] fmt_code;
  logic [INST_W-1:0] last_code;
  logic              hw_sel;
  logic              thumb_q;
  logic              push_acc;
  logic              consume;
  logic              pop;
  logic              store;
  logic              thumb_chg;

  assign fetch_ready = rst_n & ~full & ~flush;
  assign push_acc    = fetch_valid & fetch_ready;
  assign thumb_chg   = (thumb != thumb_q) & ~flush;
  assign consume     = dec_valid & dec_ready & ~flush & ~thumb_chg;

`ifdef DECODE_PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass    = empty & push_acc;
  assign word      = bypass ? fetch_data : rdata;
  assign dec_valid = rst_n & (~empty | bypass);
  assign pop       = consume & (~thumb | hw_sel) & ~empty;
  assign store     = push_acc
                   & ~(bypass & consume & (~thumb | hw_sel));
`else
  assign word      = rdata;
  assign dec_valid = rst_n & ~empty;
  assign pop       = consume & (~thumb | hw_sel);
  assign store     = push_acc;
`endif

  dpq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (store),
    .wdata (word_in()),
    .pop   (pop),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  function automatic logic [INST_W-1:0] word_in();
    return fetch_data;
  endfunction

  assign fmt_code = thumb
    ? {{(INST_W-HALF_W){1'b0}},
       (hw_sel ? word[INST_W-1:HALF_W] : word[HALF_W-1:0])}
    : word;

  assign dec_code = dec_valid ? fmt_code : last_code;
  assign level    = count;

  // Hold the last presented instruction so an empty queue shows no X.
  always_ff @(posedge clk) begin
    if (!rst_n)
      last_code <= '0;
    else if (dec_valid)
      last_code <= fmt_code;
  end

  // Previous instruction-set state, to spot a mode change without flush.
  always_ff @(posedge clk) begin
    thumb_q <= thumb;
  end

  // Fetch address, decode PC and halfword select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_addr <= RESET_PC & WORD_ALIGN_MASK;
      dec_pc     <= RESET_PC;
      hw_sel     <= 1'b0;
    end else if (flush) begin
      fetch_addr <= flush_pc & WORD_ALIGN_MASK;
      dec_pc     <= thumb ? (flush_pc & HALF_ALIGN_MASK)
                          : (flush_pc & WORD_ALIGN_MASK);
      hw_sel     <= thumb & flush_pc[1];
    end else begin
      if (push_acc)
        fetch_addr <= fetch_addr + 32'(ARM_PC_INC);
      if (thumb_chg) begin
        hw_sel <= 1'b0;
        dec_pc <= dec_pc & WORD_ALIGN_MASK;
      end else if (consume) begin
        dec_pc <= dec_pc + (thumb ? 32'(THUMB_PC_INC)
                                  : 32'(ARM_PC_INC));
        if (thumb)
          hw_sel <= ~hw_sel;
      end
    end
  end

endmodule
